hazard_fwd_unit: RTL and testbench

//  Produces the select codes that drive the pipeline's operand MUX instances:
//  EX-stage ALU operand forwarding, and load-use stall/bubble control for the
//  5-stage RISC-V core.

---
 rtl/hazard_fwd_unit.sv | 115 +++++++++++
 tb/tb_hazard_fwd_unit.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding for a 5-stage RISC-V pipeline.
// Tracks EX/MEM/WB destination info internally; the datapath supplies only ID fields and flush.
module hazard_fwd_unit #(
    parameter int REG_AW = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs2,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              ex_flush,
    output logic              stall,
    output logic              flush_ifid,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              rf_byp_a,
    output logic              rf_byp_b,
    output logic [CNT_W-1:0]  stall_cnt
);

    logic [REG_AW-1:0] ex_rd, ex_rs1, ex_rs2;
    logic              ex_rw, ex_mr;
    logic [REG_AW-1:0] mem_rd;
    logic              mem_rw;
    logic [REG_AW-1:0] wb_rd;
    logic              wb_rw;
    logic [CNT_W-1:0]  cnt_q;
    logic              lu;
    logic              ex_load;

    // A stage is a forward source only when it writes a non-zero register matching src.
    function automatic logic stage_hit(
        input logic              rw,
        input logic [REG_AW-1:0] rd,
        input logic [REG_AW-1:0] src
    );
        return rw & (rd != '0) & (rd == src);
    endfunction

    function automatic logic [1:0] fwd_code(
        input logic [REG_AW-1:0] src,
        input logic              m_rw,
        input logic [REG_AW-1:0] m_rd,
        input logic              w_rw,
        input logic [REG_AW-1:0] w_rd
    );
        if (stage_hit(m_rw, m_rd, src))
            return 2'b10;
        else if (stage_hit(w_rw, w_rd, src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign lu = id_valid & ex_mr & ex_rw & (ex_rd != '0) &
                ((ex_rd == id_rs1) | (id_use_rs2 & (ex_rd == id_rs2)));

    assign ex_load    = id_valid & ~lu & ~ex_flush;
    assign stall      = rst_n & lu & ~ex_flush;
    assign flush_ifid = rst_n & ex_flush;

    assign fwd_a_sel = fwd_code(ex_rs1, mem_rw, mem_rd, wb_rw, wb_rd);
    assign fwd_b_sel = fwd_code(ex_rs2, mem_rw, mem_rd, wb_rw, wb_rd);

    assign rf_byp_a  = id_valid & stage_hit(wb_rw, wb_rd, id_rs1);
    assign rf_byp_b  = id_valid & id_use_rs2 & stage_hit(wb_rw, wb_rd, id_rs2);

    assign stall_cnt = cnt_q;

    // Back end never stalls: MEM/WB advance every cycle; EX takes a bubble on stall or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_rd  <= '0;
            ex_rs1 <= '0;
            ex_rs2 <= '0;
            ex_rw  <= 1'b0;
            ex_mr  <= 1'b0;
            mem_rd <= '0;
            mem_rw <= 1'b0;
            wb_rd  <= '0;
            wb_rw  <= 1'b0;
        end else begin
            mem_rd <= ex_rd;
            mem_rw <= ex_rw;
            wb_rd  <= mem_rd;
            wb_rw  <= mem_rw;
            if (ex_load) begin
                ex_rd  <= id_rd;
                ex_rs1 <= id_rs1;
                ex_rs2 <= id_rs2;
                ex_rw  <= id_regwrite;
                ex_mr  <= id_memread;
            end else begin
                ex_rd  <= '0;
                ex_rs1 <= '0;
                ex_rs2 <= '0;
                ex_rw  <= 1'b0;
                ex_mr  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (stall && (cnt_q != '1))
            cnt_q <= cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: forwarding, load-use stall, flush priority,
// write-through bypass, counter saturation and reset during a stall.
module tb_hazard_fwd_unit;

    logic       clk;
    logic       rst_n;
    logic       id_valid;
    logic [4:0] id_rs1;
    logic [4:0] id_rs2;
    logic       id_use_rs2;
    logic [4:0] id_rd;
    logic       id_regwrite;
    logic       id_memread;
    logic       ex_flush;
    logic       stall;
    logic       flush_ifid;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       rf_byp_a;
    logic       rf_byp_b;
    logic [3:0] stall_cnt;

    int npass;
    int ntot;
    int exp_cnt;

    hazard_fwd_unit #(.REG_AW(5), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs2(id_use_rs2), .id_rd(id_rd),
        .id_regwrite(id_regwrite), .id_memread(id_memread), .ex_flush(ex_flush),
        .stall(stall), .flush_ifid(flush_ifid), .fwd_a_sel(fwd_a_sel),
        .fwd_b_sel(fwd_b_sel), .rf_byp_a(rf_byp_a), .rf_byp_b(rf_byp_b),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot = ntot + 1;
        assert (obs === exp) npass = npass + 1;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic set_id(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic fl);
        id_valid    = v;
        id_rs1      = rs1;
        id_rs2      = rs2;
        id_use_rs2  = u2;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        ex_flush    = fl;
        #1;
    endtask

    task automatic nop();
        set_id(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        npass   = 0;
        ntot    = 0;
        exp_cnt = 0;
        rst_n   = 1'b0;

        // outputs forced low while in reset, even with live ID inputs and flush
        set_id(1'b1, 5'd3, 5'd3, 1'b1, 5'd3, 1'b1, 1'b1, 1'b1);
        #2;
        chk("rst_stall", 32'(stall), 32'd0);
        chk("rst_flush", 32'(flush_ifid), 32'd0);
        chk("rst_byp_a", 32'(rf_byp_a), 32'd0);
        chk("rst_fwd_a", 32'(fwd_a_sel), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        nop();
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        tick();

        // add x5,x1,x2 ; add x6,x5,x3
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        chk("a_stall0", 32'(stall), 32'd0);
        tick();
        set_id(1'b1, 5'd5, 5'd3, 1'b1, 5'd6, 1'b1, 1'b0, 1'b0);
        chk("a_stall1", 32'(stall), 32'd0);
        tick();
        nop();
        chk("a_fwd_a_mem", 32'(fwd_a_sel), 32'd2);
        chk("a_fwd_b_none", 32'(fwd_b_sel), 32'd0);
        tick();

        // add x5 ; nop ; sub x7,x4,x5
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        tick();
        set_id(1'b1, 5'd4, 5'd5, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        chk("b_fwd_b_wb", 32'(fwd_b_sel), 32'd1);
        chk("b_fwd_a_none", 32'(fwd_a_sel), 32'd0);

        // same with rd=x0: never a forward source
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        tick();
        set_id(1'b1, 5'd4, 5'd0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        chk("b_x0_fwd_b", 32'(fwd_b_sel), 32'd0);

        // lw x8,0(x1) ; add x9,x8,x8
        repeat (3) tick();
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("c_stall_on", 32'(stall), 32'd1);
        chk("c_cnt_before", 32'(stall_cnt), 32'(exp_cnt));
        tick();
        exp_cnt = exp_cnt + 1;
        chk("c_stall_off", 32'(stall), 32'd0);
        chk("c_cnt_after", 32'(stall_cnt), 32'(exp_cnt));
        chk("c_bubble_fwd_a", 32'(fwd_a_sel), 32'd0);
        tick();
        nop();
        chk("c_fwd_a_wb", 32'(fwd_a_sel), 32'd1);
        chk("c_fwd_b_wb", 32'(fwd_b_sel), 32'd1);
        chk("c_cnt_hold", 32'(stall_cnt), 32'(exp_cnt));
        tick();

        // load-use coinciding with flush: flush wins
        repeat (3) tick();
        set_id(1'b1, 5'd1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        tick();
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
        chk("d_stall", 32'(stall), 32'd0);
        chk("d_flush", 32'(flush_ifid), 32'd1);
        tick();
        chk("d_cnt", 32'(stall_cnt), 32'(exp_cnt));
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd11, 1'b1, 1'b0, 1'b1);
        tick();
        set_id(1'b1, 5'd11, 5'd0, 1'b1, 5'd12, 1'b1, 1'b0, 1'b0);
        tick();
        nop();
        chk("d_flushed_no_fwd", 32'(fwd_a_sel), 32'd0);

        // MEM and WB both write x3; EX reads x3; WB write-through to ID
        repeat (3) tick();
        set_id(1'b1, 5'd1, 5'd2, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd4, 5'd5, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 1'b1, 5'd13, 1'b1, 1'b0, 1'b0);
        tick();
        set_id(1'b1, 5'd3, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("e_fwd_a_mem_wins", 32'(fwd_a_sel), 32'd2);
        chk("e_fwd_b_none", 32'(fwd_b_sel), 32'd0);
        chk("e_byp_a", 32'(rf_byp_a), 32'd1);
        chk("e_byp_b_rs2_x0", 32'(rf_byp_b), 32'd0);
        set_id(1'b1, 5'd0, 5'd3, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("e_byp_b_unused", 32'(rf_byp_b), 32'd0);
        set_id(1'b1, 5'd0, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("e_byp_b", 32'(rf_byp_b), 32'd1);
        chk("e_byp_a_x0", 32'(rf_byp_a), 32'd0);
        set_id(1'b0, 5'd3, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
        chk("e_byp_a_invalid", 32'(rf_byp_a), 32'd0);

        // lw x8,0(x8) held in ID: stalls every other cycle; counter saturates
        nop();
        repeat (3) tick();
        set_id(1'b1, 5'd8, 5'd0, 1'b0, 5'd8, 1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 32; k++) begin
            chk("f_stall_pattern", 32'(stall), 32'(k % 2));
            tick();
            if ((k % 2) == 1 && exp_cnt < 15) exp_cnt = exp_cnt + 1;
            chk("f_cnt", 32'(stall_cnt), 32'(exp_cnt));
        end
        chk("f_cnt_sat", 32'(stall_cnt), 32'hF);
        tick();
        chk("f_stall_again", 32'(stall), 32'd1);
        chk("f_cnt_stuck", 32'(stall_cnt), 32'hF);

        // reset asserted mid-stall
        rst_n = 1'b0;
        #1;
        chk("g_rst_stall", 32'(stall), 32'd0);
        chk("g_rst_cnt", 32'(stall_cnt), 32'd0);
        nop();
        rst_n = 1'b1;
        tick();
        chk("g_post_cnt", 32'(stall_cnt), 32'd0);
        chk("g_post_fwd_a", 32'(fwd_a_sel), 32'd0);
        set_id(1'b1, 5'd8, 5'd8, 1'b1, 5'd9, 1'b1, 1'b0, 1'b0);
        chk("g_post_stall", 32'(stall), 32'd0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
